// File: rtl/move_sequencer_pkg.sv
// Shared constants, state encoding and move-code helpers for the move sequencer.
// A batch word carries NIBBLES move codes, most significant nibble first.
package move_sequencer_pkg;

  localparam int NIBBLES        = 15;
  localparam int NIBBLE_W       = 4;
  localparam int WORD_W         = NIBBLES * NIBBLE_W;
  localparam int LAST_BATCH_DEF = 48;

  localparam logic [3:0] MV_PAD = 4'd0;
  localparam logic [3:0] MV_R   = 4'd2;
  localparam logic [3:0] MV_RI  = 4'd3;
  localparam logic [3:0] MV_U   = 4'd4;
  localparam logic [3:0] MV_UI  = 4'd5;
  localparam logic [3:0] MV_F   = 4'd6;
  localparam logic [3:0] MV_FI  = 4'd7;
  localparam logic [3:0] MV_L   = 4'd8;
  localparam logic [3:0] MV_LI  = 4'd9;
  localparam logic [3:0] MV_B   = 4'd10;
  localparam logic [3:0] MV_BI  = 4'd11;
  localparam logic [3:0] MV_D   = 4'd12;
  localparam logic [3:0] MV_DI  = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT     = 3'd2,
    S_UNPACK   = 3'd3,
    S_THROTTLE = 3'd4,
    S_FINISH   = 3'd5
  } state_e;

  function automatic logic is_move(input logic [3:0] code);
    case (code)
      MV_R, MV_RI, MV_U, MV_UI, MV_F, MV_FI,
      MV_L, MV_LI, MV_B, MV_BI, MV_D, MV_DI: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] code);
    if (is_move(code) || (code == MV_PAD)) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO for queued move codes; head is visible the cycle after a push.
module move_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == {CNT_W{1'b0}});
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  move_fifo_chk u_chk (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .full  (full)
  );

endmodule

// File: rtl/move_fifo_chk.sv
// Property checker for the move FIFO; kept apart from the datapath.
module move_fifo_chk (
  input logic clock,
  input logic reset,
  input logic push,
  input logic full
);

  // The sequencer throttles requests so a full FIFO is never pushed.
  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset) !(push && full))
    else $error("move_fifo: push while full, entry dropped");

endmodule

// File: rtl/move_sequencer.sv
// Requests move batches from the generator, unpacks their nibbles into a FIFO
// and streams them to the motor driver with valid/ready handshaking.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int LAST_BATCH   = LAST_BATCH_DEF,
  parameter int FIFO_DEPTH   = 32,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              request_moves,
  output logic [5:0]        counter,
  input  logic [WORD_W-1:0] moves_in,
  input  logic              new_moves,
  output logic [3:0]        move_code,
  output logic              move_valid,
  input  logic              move_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WT_W  = $clog2(WAIT_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [5:0]          counter_q, counter_d;
  logic [1:0]          error_q, error_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [3:0]          nib_q, nib_d;
  logic [WT_W-1:0]     wait_q, wait_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [NIBBLE_W-1:0] head_nib;
  logic                push;
  logic                pop;
  logic [3:0]          fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  assign head_nib      = word_q[WORD_W-1 -: NIBBLE_W];
  assign pop           = !fifo_empty && move_ready;
  assign move_valid    = !fifo_empty;
  assign move_code     = fifo_empty ? 4'd0 : fifo_head;
  assign request_moves = req_q;
  assign counter       = counter_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    error_d   = error_q;
    word_d    = word_q;
    nib_d     = nib_q;
    wait_d    = wait_q;
    done_d    = 1'b0;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          counter_d = 6'd0;
          error_d   = 2'b00;
          state_d   = S_REQ;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_REQ: begin
        wait_d  = {WT_W{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (new_moves) begin
          word_d  = moves_in;
          nib_d   = 4'd0;
          state_d = S_UNPACK;
        end else if (wait_q == WT_W'(WAIT_TIMEOUT - 1)) begin
          // Retry the same batch; the flag stays set until the next start.
          error_d[0] = 1'b1;
          state_d    = S_REQ;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_UNPACK: begin
        push   = is_move(head_nib);
        word_d = {word_q[WORD_W-NIBBLE_W-1:0], {NIBBLE_W{1'b0}}};
        if (is_illegal(head_nib)) begin
          error_d[1] = 1'b1;
        end else begin
          error_d[1] = error_q[1];
        end
        if (nib_q == 4'(NIBBLES - 1)) begin
          if (counter_q == 6'(LAST_BATCH)) begin
            state_d = S_FINISH;
          end else begin
            counter_d = counter_q + 6'd1;
            state_d   = S_THROTTLE;
          end
        end else begin
          nib_d = nib_q + 4'd1;
        end
      end
      S_THROTTLE: begin
        // Only ask for another batch once a full batch is guaranteed to fit.
        if (fifo_count <= CNT_W'(FIFO_DEPTH - NIBBLES)) begin
          state_d = S_REQ;
        end else begin
          state_d = S_THROTTLE;
        end
      end
      S_FINISH: begin
        if (fifo_empty) begin
          done_d    = 1'b1;
          counter_d = 6'd0;
          state_d   = S_IDLE;
        end else begin
          state_d   = S_FINISH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      counter_q <= 6'd0;
      error_q   <= 2'b00;
      word_q    <= '0;
      nib_q     <= 4'd0;
      wait_q    <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      error_q   <= error_d;
      word_q    <= word_d;
      nib_q     <= nib_d;
      wait_q    <= wait_d;
      req_q     <= req_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NIBBLE_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (head_nib),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench: a batch table drives a generator model through full scan runs,
// plus hand-written sequences for timeout, stall and mid-run reset.
module tb_move_sequencer;

  localparam int LAST = 48;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        new_moves = 1'b0;
  logic        move_ready = 1'b0;
  logic [59:0] moves_in = '0;
  logic        request_moves;
  logic [5:0]  counter;
  logic [3:0]  move_code;
  logic        move_valid;
  logic        busy;
  logic        done;
  logic [1:0]  error;

  move_sequencer #(.LAST_BATCH(LAST), .FIFO_DEPTH(32), .WAIT_TIMEOUT(15)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .request_moves (request_moves),
    .counter       (counter),
    .moves_in      (moves_in),
    .new_moves     (new_moves),
    .move_code     (move_code),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [59:0] word;
    logic [59:0] exp;   // expected codes in emission order, right-aligned
    int          n;
    int          batch;
    int          run;
  } vec_t;

  vec_t        vt [6];
  logic [59:0] batch_word [0:LAST];
  logic [3:0]  got [$];
  logic [3:0]  expq [$];
  int          exp_req [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          req_idx, done_cnt, pending, stall_left, silent_batch, stall_batch;
  bit          silent_used, inject_start, prev_valid;
  logic [3:0]  prev_code;
  logic [5:0]  reply_ctr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setup(input int run_id, input int silent, input int stall, input bit inj);
    logic [59:0] tmp;
    got.delete(); expq.delete(); exp_req.delete();
    req_idx = 0; done_cnt = 0; pending = 0; stall_left = 0;
    silent_used = 1'b0; prev_valid = 1'b0; prev_code = 4'd0;
    silent_batch = silent; stall_batch = stall; inject_start = inj;
    for (int b = 0; b <= LAST; b++) begin
      batch_word[b] = '0;
      exp_req.push_back(b);
      if (b == silent) exp_req.push_back(b);
      for (int v = 0; v < 6; v++) begin
        if (vt[v].run == run_id && vt[v].batch == b) begin
          batch_word[b] = vt[v].word;
          tmp = vt[v].exp;
          for (int k = 0; k < vt[v].n; k++) expq.push_back(tmp[4*(vt[v].n-1-k) +: 4]);
        end
      end
    end
  endtask

  // One cycle: generator model, consumer model and per-cycle checks at the falling edge.
  task automatic step();
    bit skip;
    @(negedge clock);
    start = 1'b0;
    if (inject_start && req_idx == 10) begin
      start = 1'b1;
      inject_start = 1'b0;
    end
    new_moves = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        new_moves = 1'b1;
        moves_in  = batch_word[reply_ctr];
      end
    end
    if (!move_ready && prev_valid && move_valid) check("stall_code_stable", move_code, prev_code);
    if (stall_left > 0) begin
      stall_left--;
      move_ready = 1'b0;
    end else begin
      move_ready = 1'b1;
    end
    prev_valid = move_valid;
    prev_code  = move_code;
    if (move_valid && move_ready) got.push_back(move_code);
    if (request_moves) begin
      skip = 1'b0;
      if (req_idx < exp_req.size()) check("request_counter", counter, exp_req[req_idx]);
      else check("request_total", req_idx + 1, exp_req.size());
      req_idx++;
      if (int'(counter) == silent_batch) begin
        if (silent_used) check("timeout_flag_on_retry", error[0], 1'b1);
        else begin
          silent_used = 1'b1;
          skip = 1'b1;
        end
      end
      if (!skip) begin
        pending   = 2;
        reply_ctr = counter;
      end
      if (int'(counter) == stall_batch) stall_left = 20;
    end
    if (done) begin
      done_cnt++;
      check("done_after_last_accept", got.size(), expq.size());
      check("done_fifo_empty", move_valid, 1'b0);
    end
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] exp_err);
    int cyc = 0;
    @(negedge clock);
    start = 1'b1;
    move_ready = 1'b1;
    while (done_cnt == 0 && cyc < 4000) begin
      step();
      cyc++;
    end
    repeat (5) step();
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_counter_cleared"}, counter, 6'd0);
    check({tag, "_request_count"}, req_idx, exp_req.size());
    check({tag, "_move_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) check({tag, "_move_code"}, got[i], expq[i]);
    check({tag, "_error_flags"}, error, exp_err);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    bit found, any_valid, any_busy;
    vt[0] = '{60'h000000000083745, 60'h83745, 5, 0, 0};
    vt[1] = '{60'h23456789ABCD234, 60'h23456789ABCD234, 15, 40, 0};
    vt[2] = '{60'h0000000002050C0, 60'h25C, 3, 7, 0};
    vt[3] = '{60'h00000000000009D, 60'h9D, 2, 48, 0};
    vt[4] = '{60'h0000000000000E4, 60'h4, 1, 2, 1};
    vt[5] = '{60'h1F0000000000002, 60'h2, 1, 3, 1};

    repeat (3) @(negedge clock);
    check("reset_move_code", move_code, 4'd0);
    check("reset_move_valid", move_valid, 1'b0);
    check("reset_request", request_moves, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_counter", counter, 6'd0);
    check("reset_error", error, 2'b00);
    reset = 1'b0;

    // Clean run with a 20-cycle stall on batch 40 and an ignored start mid-run.
    setup(0, -1, 40, 1'b1);
    run_and_check("run_clean", 2'b00);

    // Timeout on batch 5 plus illegal codes in batches 2 and 3.
    setup(1, 5, -1, 1'b0);
    run_and_check("run_errors", 2'b11);

    // Reset during the 7th unpack cycle of a full batch.
    setup(2, -1, -1, 1'b0);
    @(negedge clock);
    start = 1'b1;
    move_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (request_moves) found = 1'b1;
      else @(negedge clock);
    end
    check("rst_run_request_seen", found, 1'b1);
    check("start_clears_error", error, 2'b00);
    @(negedge clock);
    new_moves = 1'b1;
    moves_in  = 60'h23456789ABCD234;
    @(negedge clock);
    new_moves = 1'b0;
    repeat (6) @(negedge clock);
    check("valid_before_reset", move_valid, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("midrst_move_code", move_code, 4'd0);
    check("midrst_move_valid", move_valid, 1'b0);
    check("midrst_request", request_moves, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_counter", counter, 6'd0);
    check("midrst_error", error, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    any_valid = 1'b0;
    any_busy  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      new_moves  = (i == 5);
      move_ready = 1'b1;
      any_valid  = any_valid | move_valid;
      any_busy   = any_busy | busy;
    end
    check("no_valid_after_reset", any_valid, 1'b0);
    check("idle_after_reset", any_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
